// File: rtl/byte_round_ctrl_if.sv
// Control/status bundle for the byte round controller.
// Master drives strikes and timing pulses; slave reports round status.
interface byte_round_ctrl_if;
    logic       Start;
    logic       SecTick;
    logic       Hit;
    logic       Miss;
    logic [1:0] State;
    logic [3:0] TimeOnes;
    logic [3:0] TimeTens;
    logic [3:0] ScoreOnes;
    logic [3:0] ScoreTens;
    logic       RoundActive;
    logic       GameOver;

    modport master (
        output Start, SecTick, Hit, Miss,
        input  State, TimeOnes, TimeTens,
        input  ScoreOnes, ScoreTens,
        input  RoundActive, GameOver
    );

    modport slave (
        input  Start, SecTick, Hit, Miss,
        output State, TimeOnes, TimeTens,
        output ScoreOnes, ScoreTens,
        output RoundActive, GameOver
    );
endinterface

// File: rtl/byte_round_ctrl.sv
// Round controller: preroll countdown, timed play, BCD score and timer.
// Every output is a register; reset is asynchronous and active-low.
module byte_round_ctrl #(
    parameter int ROUND_SECONDS   = 60,
    parameter int PREROLL_SECONDS = 3
) (
    input logic         ClockIn,
    input logic         Resetn,
    byte_round_ctrl_if.slave Bus
);
    typedef enum logic [1:0] {
        Idle    = 2'b00,
        Preroll = 2'b01,
        Play    = 2'b10,
        Over    = 2'b11
    } stateT;

    localparam logic [3:0] RoundTens = 4'(ROUND_SECONDS / 10);
    localparam logic [3:0] RoundOnes = 4'(ROUND_SECONDS % 10);
    localparam logic [3:0] PreOnes   = 4'(PREROLL_SECONDS);

    stateT      state;
    logic [3:0] timeOnes;
    logic [3:0] timeTens;
    logic [3:0] scoreOnes;
    logic [3:0] scoreTens;
    logic       roundActive;
    logic       gameOver;

    logic timeIsOne;
    logic timeIsZero;
    logic scoreIsMax;
    logic scoreIsZero;
    logic doInc;
    logic doDec;

    assign timeIsOne   = (timeTens == 4'd0) && (timeOnes == 4'd1);
    assign timeIsZero  = (timeTens == 4'd0) && (timeOnes == 4'd0);
    assign scoreIsMax  = (scoreTens == 4'd9) && (scoreOnes == 4'd9);
    assign scoreIsZero = (scoreTens == 4'd0) && (scoreOnes == 4'd0);
    assign doInc       = Bus.Hit && !Bus.Miss;
    assign doDec       = Bus.Miss && !Bus.Hit;

    // Round FSM with timer, score and status registers.
    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state       <= Idle;
            timeOnes    <= 4'd0;
            timeTens    <= 4'd0;
            scoreOnes   <= 4'd0;
            scoreTens   <= 4'd0;
            roundActive <= 1'b0;
            gameOver    <= 1'b0;
        end else begin
            gameOver <= 1'b0;
            unique case (state)
                Idle, Over: begin
                    // Start beats a coincident SecTick: load preroll untouched.
                    if (Bus.Start) begin
                        state     <= Preroll;
                        timeTens  <= 4'd0;
                        timeOnes  <= PreOnes;
                        scoreTens <= 4'd0;
                        scoreOnes <= 4'd0;
                    end
                end
                Preroll: begin
                    if (Bus.SecTick) begin
                        if (timeIsOne) begin
                            state       <= Play;
                            timeTens    <= RoundTens;
                            timeOnes    <= RoundOnes;
                            roundActive <= 1'b1;
                        end else if (!timeIsZero) begin
                            timeOnes <= timeOnes - 4'd1;
                        end
                    end
                end
                Play: begin
                    // Score moves even on the terminating tick.
                    if (doInc && !scoreIsMax) begin
                        if (scoreOnes == 4'd9) begin
                            scoreOnes <= 4'd0;
                            scoreTens <= scoreTens + 4'd1;
                        end else begin
                            scoreOnes <= scoreOnes + 4'd1;
                        end
                    end else if (doDec && !scoreIsZero) begin
                        if (scoreOnes == 4'd0) begin
                            scoreOnes <= 4'd9;
                            scoreTens <= scoreTens - 4'd1;
                        end else begin
                            scoreOnes <= scoreOnes - 4'd1;
                        end
                    end
                    if (Bus.SecTick) begin
                        if (timeIsOne) begin
                            state       <= Over;
                            timeOnes    <= 4'd0;
                            roundActive <= 1'b0;
                            gameOver    <= 1'b1;
                        end else if (!timeIsZero) begin
                            if (timeOnes == 4'd0) begin
                                timeOnes <= 4'd9;
                                timeTens <= timeTens - 4'd1;
                            end else begin
                                timeOnes <= timeOnes - 4'd1;
                            end
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    assign Bus.State       = state;
    assign Bus.TimeOnes    = timeOnes;
    assign Bus.TimeTens    = timeTens;
    assign Bus.ScoreOnes   = scoreOnes;
    assign Bus.ScoreTens   = scoreTens;
    assign Bus.RoundActive = roundActive;
    assign Bus.GameOver    = gameOver;
endmodule

// File: doc/byte_round_ctrl.md
BYTE_ROUND_CTRL -- requirements
Module: byte_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_SECONDS, default 60, round length in seconds, legal range 1-99.
REQ-002 SHALL have parameter PREROLL_SECONDS, default 3, pre-round countdown length in seconds, legal range 1-9.
REQ-003 Port ClockIn  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port Resetn  input  1  asynchronous, active-low reset.
REQ-005 Port Start  input  1  one-cycle request to begin a round.
REQ-006 Port SecTick  input  1  one-cycle enable, asserted once per second by the upstream rate divider.
REQ-007 Port Hit  input  1  one-cycle pulse for a successful strike; already synchronised and debounced.
REQ-008 Port Miss  input  1  one-cycle pulse for a wrong or empty strike; already synchronised and debounced.
REQ-009 Port State  output  2  00 IDLE, 01 PREROLL, 10 PLAY, 11 OVER.
REQ-010 Port TimeOnes / TimeTens  output  4 each  BCD seconds remaining, fed to the hex decoders.
REQ-011 Port ScoreOnes / ScoreTens  output  4 each  BCD score, range 00-99.
REQ-012 Port RoundActive  output  1  high only in PLAY.
REQ-013 Port GameOver  output  1  one-cycle pulse on the PLAY->OVER transition.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, PREROLL, PLAY and OVER; all outputs SHALL be registered.
REQ-015 IDLE: Start=1 SHALL clear the score and load Time with PREROLL_SECONDS (tens digit 0). The FSM SHALL enter PREROLL on the next edge.
REQ-016 PREROLL: each SecTick SHALL decrement Time by 1.
REQ-017 PREROLL: a SecTick while Time=01 SHALL load Time with ROUND_SECONDS and enter PLAY.
REQ-018 PLAY: each SecTick SHALL decrement Time as a 2-digit BCD value; ones 0 with tens>0 SHALL give ones=9 and tens-1.
REQ-019 PLAY: a SecTick while Time=01 SHALL set Time=00, enter OVER and pulse GameOver for exactly one cycle.
REQ-020 Time SHALL never wrap below 00; SecTick in IDLE or OVER SHALL be ignored.
REQ-021 In PLAY only, Hit SHALL increment the score by 1 in BCD; the score SHALL saturate at 99.
REQ-022 In PLAY only, Miss SHALL decrement the score by 1; the score SHALL saturate at 00.
REQ-023 Hit and Miss in the same cycle SHALL leave the score unchanged.
REQ-024 A Hit or Miss coincident with the terminating SecTick (REQ-019) SHALL still be applied.
REQ-025 Hit and Miss outside PLAY SHALL be ignored.
REQ-026 Start in PREROLL or PLAY SHALL be ignored.
REQ-027 Start in OVER SHALL behave as in IDLE (REQ-015), restarting PREROLL with the score cleared.
REQ-028 OVER SHALL hold the final score and Time=00 until Start or reset.
REQ-029 Start and SecTick in the same cycle in IDLE/OVER: Start SHALL win; that SecTick SHALL NOT decrement the newly loaded preroll value.
REQ-030 All state-change latency from an input pulse to the updated output SHALL be exactly one clock.

Reset
REQ-031 Resetn=0 SHALL immediately, without a clock, force State=IDLE, Time=00, Score=00, RoundActive=0, GameOver=0.
REQ-032 Reset asserted mid-PREROLL or mid-PLAY SHALL abort the round; no GameOver pulse SHALL be produced.
REQ-033 After Resetn deasserts, the block SHALL remain in IDLE until Start.

Verification
REQ-034 Start round (ROUND_SECONDS=60, PREROLL_SECONDS=3) -> Time steps 3,2,1 over three SecTicks, then PLAY shows 60,59,...,50,49...; after 3+60 SecTicks State=OVER with Time=00 and a single one-cycle GameOver.
REQ-035 In PLAY, 101 Hits -> score counts 00..99 with correct BCD carries (09->10, 19->20) and holds 99; then 1 Miss -> 98.
REQ-036 In PLAY with score 00: Miss -> 00. Hit+Miss same cycle at score 05 -> 05. Hit on the final SecTick at score 12 -> 13 held in OVER.
REQ-037 Hits, Misses and Start during PREROLL -> no score change and no restart; SecTick in IDLE -> Time stays 00.
REQ-038 Resetn pulsed low asynchronously mid-PLAY (Time=37, score=21) -> outputs zero before the next edge, State=IDLE, no GameOver.
REQ-039 In OVER, Start coincident with SecTick -> PREROLL with Time=03 and score 00 on the next edge.
